// File: rtl/score_display_ctrl.sv
// score_display_ctrl: Pong BCD score/games keeper with win detection, blink timer and 8-digit display word.
module score_display_ctrl #(
  parameter int WIN_SCORE = 11,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        point_l,
  input  logic        point_r,
  input  logic        new_game,
  output logic [31:0] x_out,
  output logic        game_over,
  output logic        winner
);
  localparam logic [0:0] PLAY = 1'b0;
  localparam logic [0:0] WIN  = 1'b1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    return s[3:0] == 4'd9 ? {s[7:4] + 4'd1, 4'd0} : s + 8'd1;
  endfunction
  function automatic logic [3:0] sat_inc(input logic [3:0] g);
    return g == 4'd9 ? g : g + 4'd1;
  endfunction
  logic [0:0]    state;
  logic [7:0]    score_l, score_r, next_l, next_r;
  logic [3:0]    games_l, games_r;
  logic          blink_on, win_l, win_r, blank;
  logic [CW-1:0] blink_cnt;
  always_comb begin
    next_l = point_l ? bcd_inc(score_l) : score_l;
    next_r = point_r ? bcd_inc(score_r) : score_r;
    win_l  = next_l == WIN_BCD;
    win_r  = next_r == WIN_BCD;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PLAY;
      score_l   <= 8'h00;
      score_r   <= 8'h00;
      games_l   <= 4'd0;
      games_r   <= 4'd0;
      blink_on  <= 1'b1;
      blink_cnt <= '0;
      winner    <= 1'b0;
    end else if (state == PLAY) begin
      if (new_game) begin
        score_l <= 8'h00;
        score_r <= 8'h00;
      end else begin
        score_l <= next_l;
        score_r <= next_r;
        if (win_l || win_r) begin
          state     <= WIN;
          winner    <= !win_l;
          games_l   <= win_l ? sat_inc(games_l) : games_l;
          games_r   <= win_l ? games_r : sat_inc(games_r);
          blink_cnt <= '0;
          blink_on  <= 1'b1;
        end
      end
    end else if (new_game) begin
      state     <= PLAY;
      score_l   <= 8'h00;
      score_r   <= 8'h00;
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == TERM) begin
      blink_cnt <= '0;
      blink_on  <= !blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
  // Display word is a pure function of state registers, so it carries no input-to-output path.
  always_comb begin
    blank     = state == WIN && !blink_on;
    x_out     = {blank && !winner ? 8'hEE : score_l, 4'h0, games_l, games_r, 4'h0,
                 blank && winner ? 8'hEE : score_r};
    game_over = state == WIN;
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: randomized and directed checks of score_display_ctrl against a decimal-arithmetic model.
module tb_score_display_ctrl;
  localparam int W  = 11;
  localparam int BD = 4;
  logic        clk = 0, reset = 1, point_l = 0, point_r = 0, new_game = 0;
  logic [31:0] x_out;
  logic        game_over, winner;
  int errs = 0, checks = 0;
  int m_sl, m_sr, m_gl, m_gr, m_wc;
  bit m_win, m_wnr;

  score_display_ctrl #(.WIN_SCORE(W), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .point_l(point_l), .point_r(point_r), .new_game(new_game),
    .x_out(x_out), .game_over(game_over), .winner(winner));

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [31:0] exp_x();
    bit blank;
    blank = m_win && ((m_wc / BD) % 2 == 1);
    return {blank && !m_wnr ? 8'hEE : bcd(m_sl), 4'h0, 4'(m_gl), 4'(m_gr), 4'h0,
            blank && m_wnr ? 8'hEE : bcd(m_sr)};
  endfunction

  task automatic model_reset();
    m_sl = 0; m_sr = 0; m_gl = 0; m_gr = 0; m_wc = 0; m_win = 0; m_wnr = 0;
  endtask

  task automatic model_step(input bit pl, input bit pr, input bit ng);
    if (m_win) begin
      if (ng) begin m_win = 0; m_sl = 0; m_sr = 0; m_wc = 0; end
      else m_wc++;
    end else if (ng) begin
      m_sl = 0; m_sr = 0;
    end else begin
      if (pl) m_sl++;
      if (pr) m_sr++;
      if (m_sl == W || m_sr == W) begin
        m_win = 1; m_wc = 0;
        m_wnr = (m_sl != W);
        if (!m_wnr) m_gl = m_gl < 9 ? m_gl + 1 : 9;
        else m_gr = m_gr < 9 ? m_gr + 1 : 9;
      end
    end
  endtask

  task automatic step(input bit pl, input bit pr, input bit ng);
    point_l = pl; point_r = pr; new_game = ng;
    @(posedge clk);
    model_step(pl, pr, ng);
    #1;
    point_l = 0; point_r = 0; new_game = 0;
  endtask

  task automatic test_reset();
    checks += 3;
    if (x_out !== 32'h0) begin errs++; $display("FAIL reset_x got %h exp %h", x_out, 32'h0); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL reset_go got %b exp 0", game_over); end
    if (winner !== 1'b0) begin errs++; $display("FAIL reset_winner got %b exp 0", winner); end
  endtask

  task automatic test_basic();
    repeat (3) step(1, 0, 0);
    repeat (2) step(0, 1, 0);
    checks += 3;
    if (x_out !== 32'h0300_0002) begin errs++; $display("FAIL basic_x got %h exp %h", x_out, 32'h0300_0002); end
    if (x_out !== exp_x()) begin errs++; $display("FAIL basic_model got %h exp %h", x_out, exp_x()); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL basic_go got %b exp 0", game_over); end
  endtask

  task automatic test_carry();
    step(0, 0, 1);
    repeat (10) step(1, 0, 0);
    checks += 2;
    if (x_out !== 32'h1000_0000) begin errs++; $display("FAIL carry_x got %h exp %h", x_out, 32'h1000_0000); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL carry_go got %b exp 0", game_over); end
    step(1, 0, 0);
    checks += 3;
    if (x_out !== 32'h1101_0000) begin errs++; $display("FAIL win_x got %h exp %h", x_out, 32'h1101_0000); end
    if (game_over !== 1'b1) begin errs++; $display("FAIL win_go got %b exp 1", game_over); end
    if (winner !== 1'b0) begin errs++; $display("FAIL win_winner got %b exp 0", winner); end
  endtask

  task automatic test_blink();
    logic [31:0] lit;
    for (int i = 1; i <= 3 * BD; i++) begin
      step(0, $urandom_range(0, 1) == 1, 0);
      lit = ((i / BD) % 2 == 1) ? 32'hEE01_0000 : 32'h1101_0000;
      checks += 2;
      if (x_out !== lit) begin errs++; $display("FAIL blink_x cyc %0d got %h exp %h", i, x_out, lit); end
      if (x_out !== exp_x()) begin errs++; $display("FAIL blink_model cyc %0d got %h exp %h", i, x_out, exp_x()); end
    end
  endtask

  task automatic test_both();
    step(0, 0, 1);
    checks += 1;
    if (game_over !== 1'b0) begin errs++; $display("FAIL ng_win_go got %b exp 0", game_over); end
    repeat (10) step(1, 1, 0);
    checks += 1;
    if (x_out !== exp_x()) begin errs++; $display("FAIL both_1010 got %h exp %h", x_out, exp_x()); end
    step(1, 1, 0);
    checks += 4;
    if (x_out !== exp_x()) begin errs++; $display("FAIL both_x got %h exp %h", x_out, exp_x()); end
    if (x_out[31:24] !== 8'h11 || x_out[7:0] !== 8'h11) begin errs++; $display("FAIL both_scores got %h exp 11/11", x_out); end
    if (winner !== 1'b0) begin errs++; $display("FAIL both_winner got %b exp 0", winner); end
    if (x_out[15:12] !== 4'h0) begin errs++; $display("FAIL both_games_r got %h exp 0", x_out[15:12]); end
  endtask

  task automatic test_new_game_priority();
    step(0, 0, 1);
    checks += 2;
    if (game_over !== 1'b0) begin errs++; $display("FAIL ngw_go got %b exp 0", game_over); end
    if (x_out !== exp_x()) begin errs++; $display("FAIL ngw_x got %h exp %h", x_out, exp_x()); end
    repeat (5) step(1, 0, 0);
    repeat (7) step(0, 1, 0);
    checks += 1;
    if (x_out !== exp_x()) begin errs++; $display("FAIL pre_ng got %h exp %h", x_out, exp_x()); end
    step(0, 1, 1);
    checks += 2;
    if (x_out !== exp_x()) begin errs++; $display("FAIL ng_prio got %h exp %h", x_out, exp_x()); end
    if (x_out[31:24] !== 8'h00 || x_out[7:0] !== 8'h00) begin errs++; $display("FAIL ng_prio_scores got %h exp 00/00", x_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 30) == 0);
      checks += 3;
      if (x_out !== exp_x()) begin errs++; $display("FAIL rnd_x cyc %0d got %h exp %h", i, x_out, exp_x()); end
      if (game_over !== m_win) begin errs++; $display("FAIL rnd_go cyc %0d got %b exp %b", i, game_over, m_win); end
      if (winner !== m_wnr) begin errs++; $display("FAIL rnd_winner cyc %0d got %b exp %b", i, winner, m_wnr); end
    end
  endtask

  task automatic test_reset_mid_blink();
    reset = 1; #1; reset = 0; model_reset();
    repeat (3) begin
      step(0, 0, 1);
      repeat (W) step(1, 0, 0);
    end
    repeat (BD + 1) step(0, 0, 0);
    checks += 1;
    if (x_out !== 32'hEE03_0000) begin errs++; $display("FAIL pre_reset got %h exp %h", x_out, 32'hEE03_0000); end
    reset = 1; #1;
    model_reset();
    checks += 2;
    if (x_out !== 32'h0) begin errs++; $display("FAIL async_x got %h exp %h", x_out, 32'h0); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL async_go got %b exp 0", game_over); end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    step(0, 1, 0);
    checks += 1;
    if (x_out !== 32'h0000_0001) begin errs++; $display("FAIL post_reset got %h exp %h", x_out, 32'h0000_0001); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_carry();
    test_blink();
    test_both();
    test_new_game_priority();
    test_random();
    test_reset_mid_blink();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
